rr_arbiter_8: RTL and testbench

Round-robin arbiter sharing one resource between 8 requesters. It produces a registered one-hot grant, its 3-bit encoded index (the same one-hot to binary mapping as the 8-to-3 encoder: bit k maps to k), and a valid flag. It holds the grant until the owner releases or a hold timeout fires. It sits in front of any shared datapath resource whose select input takes the encoded index.

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_pick8.sv | 37 +++
 rtl/rr_arbiter_8.sv | 76 +++++++
 tb/tb_rr_arbiter_8.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state type and encoder for the 8-way round-robin arbiter
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Bit k maps to k; anything that is not exactly one-hot maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    case (oh)
      8'b0000_0001: idx = 3'd0;
      8'b0000_0010: idx = 3'd1;
      8'b0000_0100: idx = 3'd2;
      8'b0000_1000: idx = 3'd3;
      8'b0001_0000: idx = 3'd4;
      8'b0010_0000: idx = 3'd5;
      8'b0100_0000: idx = 3'd6;
      8'b1000_0000: idx = 3'd7;
      default:      idx = 3'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational pick of the first unmasked request at or after ptr
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] pick
);

  logic [N_REQ-1:0] eff;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] src;
  logic [IDX_W-1:0] off;

  always_comb begin
    eff   = req & ~mask;
    rot   = '0;
    src   = '0;
    found = 1'b0;
    off   = '0;
    // Rotate so that ptr lands on bit 0; the 3-bit sum wraps naturally.
    for (int i = 0; i < N_REQ; i++) begin
      src    = ptr + IDX_W'(i);
      rot[i] = eff[src];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    pick = ptr + off;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with registered grant and hold timeout
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic              hold_max;
  logic              release_now;
  logic              force_only;
  logic [N_REQ-1:0]  mask;
  logic              found;
  logic [IDX_W-1:0]  pick;

  always_comb begin
    hold_max    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    release_now = (state == GRANT) && (done || !req[gnt_idx] || hold_max);
    force_only  = (state == GRANT) && hold_max && !done && req[gnt_idx];
    // The releasing owner is excluded so it cannot win the very next cycle.
    mask        = (state == GRANT) ? (N_REQ'(1) << gnt_idx) : '0;
  end

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .mask  (mask),
    .found (found),
    .pick  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= force_only;
      if ((state == IDLE || release_now) && found) begin
        state     <= GRANT;
        gnt       <= N_REQ'(1) << pick;
        gnt_idx   <= pick;
        gnt_valid <= 1'b1;
        ptr       <= pick + IDX_W'(1);
        hold_cnt  <= '0;
      end else if (release_now) begin
        state     <= IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        hold_cnt  <= '0;
      end else if (state == GRANT) begin
        hold_cnt  <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8 with a behavioural model
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int compared = 0;
  int mismatched = 0;

  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_to;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
  endtask

  // Ownership view: who owns the resource, for how long, and who is next in line.
  task automatic model_step();
    int  excl;
    int  pick;
    int  j;
    bit  arb;
    excl = -1;
    arb  = 1;
    m_to = 0;
    if (m_valid) begin
      if (done || !req[m_idx] || m_hold == MAX_HOLD - 1) begin
        m_to = (m_hold == MAX_HOLD - 1) && !done && req[m_idx];
        excl = m_idx;
      end else begin
        m_hold++;
        arb = 0;
      end
    end
    if (arb) begin
      pick = -1;
      for (int k = 0; k < 8; k++) begin
        j = (m_ptr + k) % 8;
        if (pick < 0 && req[j] && j != excl) pick = j;
      end
      if (pick >= 0) begin
        m_valid = 1; m_idx = pick; m_ptr = (pick + 1) % 8; m_hold = 0;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = 8'h00; done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'h00; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared += 4;
    if (gnt !== 8'h00) begin mismatched++; $display("FAIL reset_gnt: got %h want 00", gnt); end
    if (gnt_idx !== 3'd0) begin mismatched++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
    if (gnt_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
    if (timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_grant();
    req = 8'b0000_0001;
    tick();
    compared += 3;
    if (gnt !== 8'b0000_0001) begin mismatched++; $display("FAIL first_gnt: got %b want 00000001", gnt); end
    if (gnt_idx !== 3'd0) begin mismatched++; $display("FAIL first_idx: got %0d want 0", gnt_idx); end
    if (gnt_valid !== 1'b1) begin mismatched++; $display("FAIL first_valid: got %b want 1", gnt_valid); end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] want;
    apply_reset();
    req = 8'b1001_0000;
    tick();
    compared++;
    if (gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
      mismatched++; $display("FAIL b2b_first: got idx %0d valid %b want idx 4 valid 1", gnt_idx, gnt_valid);
    end
    done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      want = (k % 2 == 0) ? 3'd7 : 3'd4;
      compared++;
      if (gnt_idx !== want || gnt_valid !== 1'b1) begin
        mismatched++; $display("FAIL b2b_step%0d: got idx %0d valid %b want idx %0d valid 1", k, gnt_idx, gnt_valid, want);
      end
    end
    done = 1'b0; req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 8'b1000_0000;
    tick();
    req = 8'b1000_0010; done = 1'b1;
    tick();
    compared++;
    if (gnt_idx !== 3'd1 || gnt !== 8'b0000_0010) begin
      mismatched++; $display("FAIL wrap_grant: got idx %0d gnt %b want idx 1", gnt_idx, gnt);
    end
    done = 1'b0; req = 8'h00;
    tick();
    req = 8'b0000_0011;
    tick();
    compared++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      mismatched++; $display("FAIL wrap_ptr: got idx %0d want 0 (ptr should be 2)", gnt_idx);
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [7:0] g_seen [1:18];
    logic       t_seen [1:18];
    logic [2:0] i_seen [1:18];
    int held;
    int pulses;
    req = 8'b0000_1000; done = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      g_seen[i] = gnt; t_seen[i] = timeout; i_seen[i] = gnt_idx;
    end
    held = 0; pulses = 0;
    for (int i = 1; i <= 18; i++) begin
      if (i <= 16 && g_seen[i] === 8'b0000_1000) held++;
      if (t_seen[i] === 1'b1) pulses++;
    end
    compared += 4;
    if (held != 16) begin mismatched++; $display("FAIL to_held: got %0d cycles want 16", held); end
    if (g_seen[17] !== 8'h00 || t_seen[17] !== 1'b1 || i_seen[17] !== 3'd3) begin
      mismatched++; $display("FAIL to_release: got gnt %b timeout %b idx %0d want 00000000 1 3", g_seen[17], t_seen[17], i_seen[17]);
    end
    if (g_seen[18] !== 8'b0000_1000) begin mismatched++; $display("FAIL to_regrant: got %b want 00001000", g_seen[18]); end
    if (pulses != 1) begin mismatched++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_drop();
    req = 8'b0010_0000;
    tick();
    compared++;
    if (gnt_idx !== 3'd5 || gnt_valid !== 1'b1) begin
      mismatched++; $display("FAIL drop_grant: got idx %0d valid %b want 5 1", gnt_idx, gnt_valid);
    end
    req = 8'h00;
    tick();
    compared += 2;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      mismatched++; $display("FAIL drop_release: got gnt %b valid %b want 0 0", gnt, gnt_valid);
    end
    if (gnt_idx !== 3'd5 || timeout !== 1'b0) begin
      mismatched++; $display("FAIL drop_idx: got idx %0d timeout %b want 5 0", gnt_idx, timeout);
    end
  endtask

  task automatic test_async_reset();
    req = 8'b0100_0000;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      mismatched++; $display("FAIL async_reset: got gnt %b idx %0d valid %b timeout %b want all 0", gnt, gnt_idx, gnt_valid, timeout);
    end
    model_reset();
    req = 8'b0100_0001;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    compared++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      mismatched++; $display("FAIL post_reset_grant: got idx %0d valid %b want 0 1", gnt_idx, gnt_valid);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp_gnt;
    int bad;
    int to_seen;
    apply_reset();
    bad = 0; to_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) req = req ^ (8'h01 << $urandom_range(7));
      done = ($urandom_range(31) == 0);
      tick();
      exp_gnt = m_valid ? (8'h01 << m_idx) : 8'h00;
      if (m_to) to_seen++;
      compared++;
      if (gnt !== exp_gnt || gnt_valid !== m_valid || timeout !== m_to || gnt_idx !== 3'(m_idx)) begin
        mismatched++; bad++;
        if (bad <= 10)
          $display("FAIL random_c%0d: got gnt %b idx %0d valid %b to %b want gnt %b idx %0d valid %b to %b",
                   c, gnt, gnt_idx, gnt_valid, timeout, exp_gnt, m_idx, m_valid, m_to);
      end
    end
    compared++;
    if (to_seen == 0) begin mismatched++; $display("FAIL random_timeouts: got 0 timeouts want >0"); end
    req = 8'h00; done = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
